// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU sharing arbiter: ALU select codes, sequencer
// states and the native ALU width.
package alu_ctrl_pkg;

  localparam int ALU_DATA_W = 5;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_ADD = 2'b01,
    OP_OR  = 2'b10,
    OP_XOR = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/likeALU.sv
// Existing 5-bit combinational ALU: AND / ADD / OR / XOR selected by sel.
module likeALU
  import alu_ctrl_pkg::*;
(
  input  logic [4:0] a,
  input  logic [4:0] b,
  input  logic [1:0] sel,
  input  logic       c_in,
  output logic [4:0] y
);

  // Carry-out is not needed by any user, so the add truncates to 5 bits.
  always_comb begin
    y = '0;
    case (sel)
      OP_AND:  y = a & b;
      OP_ADD:  y = a + b + {4'b0, c_in};
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter between two requesters for one shared ALU; latches the
// winning operation, executes it for one cycle and holds the tagged result.
module alu_share_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][1:0]        req_op,
  input  logic [1:0][DATA_W-1:0] req_a,
  input  logic [1:0][DATA_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_id,
  output logic [CNT_W-1:0]       op_count,
  output logic                   busy
);

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic                id_q, id_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                win;
  logic [DATA_W-1:0]   alu_y;

  // On contention the requester that did not win last time goes first.
  always_comb win = (&req_valid) ? ~last_grant_q : req_valid[1];

  assign req_ready = (rst_n && state_q == IDLE && |req_valid)
                   ? (win ? 2'b10 : 2'b01) : 2'b00;

  likeALU u_alu (
    .a    (a_q),
    .b    (b_q),
    .sel  (op_q),
    .c_in (1'b0),
    .y    (alu_y)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: if (|(req_valid & req_ready)) begin
        op_d         = req_op[win];
        a_d          = req_a[win];
        b_d          = req_b[win];
        id_d         = win;
        last_grant_d = win;
        state_d      = EXEC;
      end
      EXEC: begin
        rsp_data_d = alu_y;
        rsp_id_d   = id_q;
        state_d    = RESP;
      end
      RESP: if (rsp_ready) begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      cnt_q        <= cnt_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = cnt_q;
  assign busy      = (state_q != IDLE);

endmodule
